scope_trigger_capture: RTL

- Sits directly downstream of the ADC sampling stage and consumes its 12-bit sample word plus its one-cycle refresh strobe.
- Implements oscilloscope trigger and acquisition: after arm, continuously records into a circular buffer, detects a level crossing (or a forced trigger), then freezes a window of DEPTH samples with PRETRIG samples before the trigger.
- The display/readout side reads the frozen window by logical index, where index 0 is the oldest sample.

---
 rtl/scope_pkg.sv | 21 ++
 rtl/scope_trigger_capture_if.sv | 34 +++
 rtl/scope_sample_ram.sv | 35 +++
 rtl/scope_trigger_capture.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared types and constants for the oscilloscope trigger/capture block.
//   scope_state_t : acquisition state machine encoding
//   SCOPE_DW      : default sample width
//   SCOPE_AW      : default capture buffer address width
//   sample_t      : one ADC sample word at the default width
package scope_pkg;

  localparam int SCOPE_DW = 12;
  localparam int SCOPE_AW = 8;

  typedef logic [SCOPE_DW-1:0] sample_t;

  typedef enum logic [2:0] {
    IDLE,
    PREFILL,
    WAIT_TRIG,
    POST,
    DONE
  } scope_state_t;

endpackage

// File: rtl/scope_trigger_capture_if.sv
// Sample-stream and readout bus between the ADC/display side and the
// trigger/capture block.
//   sample_data  : ADC sample, valid only while sample_valid=1
//   sample_valid : one-cycle strobe per new sample
//   rd_addr      : logical read index, 0 = oldest sample of the window
//   rd_data      : registered read data, one cycle after rd_addr
// master = ADC/display side, slave = capture block.
interface scope_trigger_capture_if
  import scope_pkg::*;
#(
  parameter int DW = SCOPE_DW,
  parameter int AW = SCOPE_AW
);

  logic [DW-1:0] sample_data;
  logic          sample_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  modport master (
    output sample_data,
    output sample_valid,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    input  rd_addr,
    output rd_data
  );

endinterface

// File: rtl/scope_sample_ram.sv
// Simple dual-port synchronous RAM holding the capture window.
//   clock   : system clock
//   reset   : asynchronous active-low reset (read register only)
//   we      : write enable
//   wr_addr : physical write address
//   wr_data : sample to store
//   rd_addr : physical read address
//   rd_data : registered read data; a same-cycle write returns the old word
module scope_sample_ram #(
  parameter int DW = 12,
  parameter int AW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: the array has no reset so it maps onto block RAM; only the
  // output register is reset.
  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/scope_trigger_capture.sv
// Oscilloscope trigger and acquisition. After arm the block records samples
// into a circular buffer, waits for a level crossing (or a forced trigger),
// then freezes a window of DEPTH samples with PRETRIG samples before the
// trigger sample. The readout side reads the frozen window by logical index.
//   clock         : system clock
//   reset         : asynchronous active-low reset
//   bus           : sample stream in, logical read port (slave side)
//   trig_level    : unsigned trigger threshold
//   trig_edge     : 0 = rising, 1 = falling
//   arm           : one-cycle pulse, starts/restarts an acquisition
//   force_trig    : one-cycle pulse, forces a trigger ("force" is a keyword)
//   armed         : high in PREFILL or WAIT_TRIG
//   triggered     : high in POST
//   done          : high in DONE, window frozen
//   capture_count : completed captures, wraps at 16 bits
module scope_trigger_capture
  import scope_pkg::*;
#(
  parameter int DW      = SCOPE_DW,
  parameter int AW      = SCOPE_AW,
  parameter int DEPTH   = 2**AW,
  parameter int PRETRIG = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  scope_trigger_capture_if.slave  bus,
  input  logic [DW-1:0]           trig_level,
  input  logic                    trig_edge,
  input  logic                    arm,
  input  logic                    force_trig,
  output logic                    armed,
  output logic                    triggered,
  output logic                    done,
  output logic [15:0]             capture_count
);

  localparam logic [AW:0]   PRE_CNT  = (AW+1)'(PRETRIG);
  localparam logic [AW:0]   POST_CNT = (AW+1)'(DEPTH - PRETRIG);
  localparam logic [AW-1:0] PRE_OFS  = AW'(PRETRIG);
  // With no pre-trigger history there is nothing to prefill.
  localparam scope_state_t  ARM_STATE = (PRETRIG == 0) ? WAIT_TRIG : PREFILL;

  scope_state_t  state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] trig_ptr;
  logic [AW:0]   cnt;
  logic [DW-1:0] prev;
  logic          prev_valid;
  logic          force_pend;

  logic          recording;
  logic          accept;
  logic          crossing;
  logic          trig_hit;
  logic [AW:0]   cnt_inc;
  logic [AW-1:0] start_ptr;
  logic [AW-1:0] rd_phys;
  logic [DW-1:0] ram_rd_data;

  assign recording = (state == PREFILL) || (state == WAIT_TRIG) || (state == POST);
  // A sample arriving together with arm belongs to neither capture.
  assign accept    = bus.sample_valid && !arm && recording;

  assign crossing = prev_valid &&
                    (trig_edge ? ((prev > trig_level) && (bus.sample_data <= trig_level))
                               : ((prev < trig_level) && (bus.sample_data >= trig_level)));

  assign trig_hit = (state == WAIT_TRIG) && accept && (force_pend || crossing);
  assign cnt_inc  = cnt + 1'b1;

  // Logical index 0 is PRETRIG samples before the trigger; AW-bit adds wrap.
  assign start_ptr = trig_ptr - PRE_OFS;
  assign rd_phys   = start_ptr + bus.rd_addr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      trig_ptr      <= '0;
      cnt           <= '0;
      prev          <= '0;
      prev_valid    <= 1'b0;
      force_pend    <= 1'b0;
      armed         <= 1'b0;
      triggered     <= 1'b0;
      done          <= 1'b0;
      capture_count <= '0;
    end else if (arm) begin
      // Arm wins over everything, including a simultaneous force.
      state      <= ARM_STATE;
      cnt        <= '0;
      prev_valid <= 1'b0;
      force_pend <= 1'b0;
      armed      <= 1'b1;
      triggered  <= 1'b0;
      done       <= 1'b0;
    end else begin
      // NOTE: every state register uses <= so all of them see this cycle's
      // values; later assignments in this block override earlier ones.
      if (force_trig && ((state == PREFILL) || (state == WAIT_TRIG))) force_pend <= 1'b1;

      if (accept) begin
        wr_ptr     <= wr_ptr + 1'b1;
        prev       <= bus.sample_data;
        prev_valid <= 1'b1;
      end

      case (state)
        PREFILL: begin
          if (accept) begin
            cnt <= cnt_inc;
            if (cnt_inc == PRE_CNT) state <= WAIT_TRIG;
          end
        end

        WAIT_TRIG: begin
          if (trig_hit) begin
            trig_ptr   <= wr_ptr;
            cnt        <= (AW+1)'(1);
            force_pend <= 1'b0;
            armed      <= 1'b0;
            if (POST_CNT == (AW+1)'(1)) begin
              // The trigger sample alone completes the window.
              state         <= DONE;
              done          <= 1'b1;
              capture_count <= capture_count + 16'd1;
            end else begin
              state     <= POST;
              triggered <= 1'b1;
            end
          end
        end

        POST: begin
          if (accept) begin
            cnt <= cnt_inc;
            if (cnt_inc == POST_CNT) begin
              state         <= DONE;
              triggered     <= 1'b0;
              done          <= 1'b1;
              capture_count <= capture_count + 16'd1;
            end
          end
        end

        default: ;
      endcase
    end
  end

  scope_sample_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .we      (accept),
    .wr_addr (wr_ptr),
    .wr_data (bus.sample_data),
    .rd_addr (rd_phys),
    .rd_data (ram_rd_data)
  );

  assign bus.rd_data = ram_rd_data;

endmodule
